// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared definitions for the PS/2 keyboard I/O responder:
//             register offsets, status/control bit positions and the
//             receive state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Register offsets as seen on m_addr[3:2]
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;

    // Status / control bit positions
    localparam int ST_VALID  = 8;
    localparam int ST_OVF    = 9;
    localparam int ST_PERR   = 10;
    localparam int CTL_FLUSH = 0;

    // Receive frame state
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_SHIFT  = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_fifo
//  Purpose  : Synchronous circular scan-code FIFO with push, pop and flush.
//  Ports    : clk, clrn          - clock, asynchronous active-low reset
//             i_push / i_din     - write request and byte
//             i_pop              - read request (ignored when empty)
//             i_flush            - empty the FIFO; wins over push and pop
//             o_full / o_empty   - occupancy flags
//             o_count            - current occupancy (PTR_W+1 bits)
//             o_count_nxt        - occupancy after this clock edge
//             o_head             - byte at the read pointer
//  Revision : 1.0  initial release
// ============================================================================
module ps2_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = 3
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             i_push,
    input  logic [7:0]       i_din,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count,
    output logic [PTR_W:0]   o_count_nxt,
    output logic [7:0]       o_head
);

    localparam logic [PTR_W:0] c_depth = FIFO_DEPTH[PTR_W:0];

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (r_count == c_depth);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted only when a pop frees the head
    // slot in the same cycle; the new byte lands in that slot.
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

    always_comb begin
        o_count_nxt = r_count;
        if (i_flush) begin
            o_count_nxt = '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   o_count_nxt = r_count + 1'b1;
                2'b01:   o_count_nxt = r_count - 1'b1;
                default: o_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= o_count_nxt;
        end
    end

    // Storage needs no reset: the head byte is masked whenever empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule : ps2_fifo
`default_nettype wire

// File: rtl/ps2_kbd_io.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_kbd_io
//  Purpose  : CPU I/O-space keyboard port. Receives PS/2 frames, queues
//             scan codes in a FIFO and answers CPU reads/writes.
//  Ports    : clk, clrn        - clock, asynchronous active-low reset
//             ps2_clk/ps2_data - raw keyboard lines (asynchronous)
//             io_rdn / io_wrn  - active-low one-cycle read / write strobes
//             addr             - m_addr[3:2]: 0 DATA, 1 STATUS, 2/3 reserved
//             d_in             - store data
//             d_out            - combinational read data
//             irq              - registered, high while FIFO non-empty
//  Revision : 1.0  initial release
// ============================================================================
module ps2_kbd_io
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int PTR_W       = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        io_rdn,
    input  logic        io_wrn,
    input  logic [1:0]  addr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        irq
);

    localparam int           c_to_w    = $clog2(TIMEOUT_CYC);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYC - 1);

    logic [2:0]        r_sclk;
    logic [2:0]        r_sdat;
    rx_state_t         r_state;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_sreg;
    logic              r_par;
    logic [c_to_w-1:0] r_tocnt;
    logic              r_ovf;
    logic              r_perr;
    logic              r_irq;

    logic              w_fall;
    logic              w_bit;
    logic              w_stop_fall;
    logic              w_par_ok;
    logic              w_push;
    logic              w_perr_set;
    logic              w_pop;
    logic              w_flush;
    logic              w_ctl_wr;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic              w_valid;
    logic [PTR_W:0]    w_count;
    logic [PTR_W:0]    w_count_nxt;
    logic [7:0]        w_head;
    logic              w_unused;

    // Only the flag-clear and flush bits of d_in are meaningful.
    assign w_unused = ^{d_in[31:11], d_in[8:1]};

    // Data is taken from the oldest synchroniser stage so it reflects the
    // line level from before the clock edge that produced the fall.
    assign w_fall      = r_sclk[2] & ~r_sclk[1];
    assign w_bit       = r_sdat[2];
    assign w_stop_fall = w_fall & (r_state == RX_STOP);
    assign w_par_ok    = ^{r_sreg, r_par};
    assign w_push      = w_stop_fall & w_bit & w_par_ok;
    assign w_perr_set  = w_stop_fall & ~w_par_ok;

    assign w_valid  = ~w_empty;
    assign w_pop    = ~io_rdn & (addr == ADDR_DATA) & w_valid;
    assign w_ctl_wr = ~io_wrn & (addr == ADDR_STATUS);
    assign w_flush  = w_ctl_wr & d_in[CTL_FLUSH];
    assign w_drop   = w_push & w_full & ~w_pop & ~w_flush;

    // ---------------------------------------------------------------------
    // Synchronisers, receive FSM and abort timer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_sclk   <= 3'b111;
            r_sdat   <= 3'b111;
            r_state  <= RX_IDLE;
            r_bitcnt <= '0;
            r_sreg   <= '0;
            r_par    <= 1'b0;
            r_tocnt  <= '0;
        end else begin
            r_sclk <= {r_sclk[1:0], ps2_clk};
            r_sdat <= {r_sdat[1:0], ps2_data};

            if ((r_state == RX_IDLE) || w_fall) r_tocnt <= '0;
            else                               r_tocnt <= r_tocnt + 1'b1;

            if (w_fall) begin
                case (r_state)
                    RX_IDLE: begin
                        if (!w_bit) begin
                            r_state  <= RX_SHIFT;
                            r_bitcnt <= '0;
                        end
                    end
                    RX_SHIFT: begin
                        r_sreg   <= {w_bit, r_sreg[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) r_state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        r_par   <= w_bit;
                        r_state <= RX_STOP;
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end else if ((r_state != RX_IDLE) && (r_tocnt == c_to_last)) begin
                // Keyboard stalled mid-frame: drop the partial frame.
                r_state <= RX_IDLE;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Scan-code FIFO
    // ---------------------------------------------------------------------
    ps2_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .clrn        (clrn),
        .i_push      (w_push),
        .i_din       (r_sreg),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt),
        .o_head      (w_head)
    );

    // ---------------------------------------------------------------------
    // Sticky flags and interrupt; a same-cycle set beats a clear
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_ovf  <= w_drop     | (r_ovf  & ~(w_ctl_wr & d_in[ST_OVF]));
            r_perr <= w_perr_set | (r_perr & ~(w_ctl_wr & d_in[ST_PERR]));
            r_irq  <= (w_count_nxt != '0);
        end
    end

    assign irq = r_irq;

    // ---------------------------------------------------------------------
    // Combinational read mux
    // ---------------------------------------------------------------------
    always_comb begin
        d_out = '0;
        if (!io_rdn) begin
            case (addr)
                ADDR_DATA: begin
                    d_out[ST_VALID] = w_valid;
                    d_out[7:0]      = w_valid ? w_head : 8'h00;
                end
                ADDR_STATUS: begin
                    d_out[ST_PERR]  = r_perr;
                    d_out[ST_OVF]   = r_ovf;
                    d_out[ST_VALID] = w_valid;
                    d_out[7:0]      = 8'(w_count);
                end
                default: d_out = '0;
            endcase
        end
    end

endmodule : ps2_kbd_io
`default_nettype wire

// File: tb/tb_ps2_kbd_io.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_kbd_io
//  Purpose  : Directed self-checking bench for ps2_kbd_io. The PS/2 bit
//             period and abort timeout are scaled down to clk cycles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_kbd_io;

    localparam int TIMEOUT_CYC = 200;
    localparam int HALF        = 8;   // clk cycles per PS/2 clock phase

    logic        clk = 1'b0;
    logic        clrn;
    logic        ps2_clk;
    logic        ps2_data;
    logic        io_rdn;
    logic        io_wrn;
    logic [1:0]  addr;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;

    ps2_kbd_io #(
        .FIFO_DEPTH  (8),
        .PTR_W       (3),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .io_rdn   (io_rdn),
        .io_wrn   (io_wrn),
        .addr     (addr),
        .d_in     (d_in),
        .d_out    (d_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        io_rdn = 1'b0;
        addr   = a;
        #2;
        chk_eq(tag, d_out, exp);
        @(posedge clk);
        #1;
        io_rdn = 1'b1;
    endtask

    task automatic wr_status(input logic [31:0] v);
        io_wrn = 1'b0;
        addr   = 2'd1;
        d_in   = v;
        @(posedge clk);
        #1;
        io_wrn = 1'b1;
        d_in   = '0;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    // Start, 8 data bits LSB first, odd parity (optionally inverted), stop.
    task automatic send_frame(input logic [7:0] v, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(v[i]);
        ps2_bit((~^v) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        tick(4);
    endtask

    initial begin
        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        io_rdn = 1'b1; io_wrn = 1'b1; addr = 2'd0; d_in = '0;
        tick(3);
        clrn = 1'b1;
        tick(2);

        // Reset state
        chk_eq("rst_irq", {31'b0, irq}, 32'h0);
        chk_eq("rst_idle_dout", d_out, 32'h0);
        rd_chk("rst_status", 2'd1, 32'h0);
        rd_chk("rst_data", 2'd0, 32'h0);

        // 1: single good frame
        send_frame(8'h1C, 1'b0);
        chk_eq("t1_irq_hi", {31'b0, irq}, 32'h1);
        rd_chk("t1_status", 2'd1, 32'h0000_0101);
        rd_chk("t1_reserved", 2'd2, 32'h0);
        rd_chk("t1_data", 2'd0, 32'h0000_011C);
        chk_eq("t1_irq_lo", {31'b0, irq}, 32'h0);
        rd_chk("t1_data_empty", 2'd0, 32'h0);

        // 2: parity error
        send_frame(8'h1C, 1'b1);
        rd_chk("t2_status", 2'd1, 32'h0000_0400);
        chk_eq("t2_irq", {31'b0, irq}, 32'h0);
        wr_status(32'h400);
        rd_chk("t2_cleared", 2'd1, 32'h0);

        // 3: overflow
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
        rd_chk("t3_status", 2'd1, 32'h0000_0308);
        for (int i = 1; i <= 8; i++) rd_chk("t3_data", 2'd0, 32'h100 + 32'(i));
        rd_chk("t3_drained", 2'd0, 32'h0);
        rd_chk("t3_ovf_only", 2'd1, 32'h0000_0200);
        wr_status(32'h200);
        rd_chk("t3_ovf_clr", 2'd1, 32'h0);

        // 4: push and pop on the same edge while full
        for (int i = 1; i <= 8; i++) send_frame(8'h10 + 8'(i), 1'b0);
        rd_chk("t4_full", 2'd1, 32'h0000_0108);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(1'(8'h19 >> i));
        ps2_bit(~^8'h19);
        ps2_data = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(2);                          // fall is detected in the next cycle
        rd_chk("t4_pop_same", 2'd0, 32'h0000_0111);
        tick(HALF - 3);
        ps2_clk = 1'b1;
        tick(4);
        rd_chk("t4_status", 2'd1, 32'h0000_0108);
        for (int i = 2; i <= 9; i++) rd_chk("t4_data", 2'd0, 32'h110 + 32'(i));
        // flush
        send_frame(8'h33, 1'b0);
        send_frame(8'h34, 1'b0);
        wr_status(32'h1);
        rd_chk("t4_flush", 2'd1, 32'h0);
        tick(1);
        chk_eq("t4_flush_irq", {31'b0, irq}, 32'h0);

        // 5: abort a stalled partial frame
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        tick(TIMEOUT_CYC + 20);
        send_frame(8'hF0, 1'b0);
        rd_chk("t5_status", 2'd1, 32'h0000_0101);
        rd_chk("t5_data", 2'd0, 32'h0000_01F0);

        // 6: reset mid-frame with bytes queued
        send_frame(8'h21, 1'b0);
        send_frame(8'h22, 1'b0);
        send_frame(8'h23, 1'b0);
        rd_chk("t6_queued", 2'd1, 32'h0000_0103);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'(i & 1));
        clrn = 1'b0;
        #2;
        chk_eq("t6_irq_in_rst", {31'b0, irq}, 32'h0);
        tick(2);
        clrn = 1'b1;
        tick(1);
        rd_chk("t6_status", 2'd1, 32'h0);
        chk_eq("t6_irq", {31'b0, irq}, 32'h0);
        send_frame(8'h5A, 1'b0);
        rd_chk("t6_status2", 2'd1, 32'h0000_0101);
        rd_chk("t6_data", 2'd0, 32'h0000_015A);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_ps2_kbd_io
`default_nettype wire
